cc_uart_core: RTL and testbench
===============================

# cc_uart_core

Parametrised full-duplex UART core for CipherCore-Lite. It replaces the fixed 8N1 transceiver behind the FPGA top with configurable data width, parity mode, stop bits and oversampling, and adds parity and framing error reporting. It sits directly under the board top on the divided system clock and drives the cipher datapath through byte-wide rx/tx handshakes.

## Interface
- CLK_FREQ, 30_000_000: system clock frequency in Hz.
- BAUD, 115_200: line rate in bit/s.
- OVERSAMPLE, 16: rx samples per bit. Must be even and at least 4.
- DATA_BITS, 8: payload bits per frame, range 5–9.
- PARITY, 0: parity mode. 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: number of transmitted stop bits, 1 or 2.
- Derived values:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer-truncated, must be at least 1.
  - BIT_CYCLES = DIV*OVERSAMPLE.
- clk  in  1  system clock. All logic is on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- rx_in  in  1  asynchronous serial input. Idle level is high.
- rx_data  out  DATA_BITS  last received payload. Resets to 0.
- rx_done  out  1  one-cycle pulse at the end of every received frame. Resets to 0.
- rx_valid  out  1  one-cycle pulse with rx_done when the frame has no errors. Resets to 0.
- rx_parity_err  out  1  parity mismatch on the last frame. Held until the next rx_done. Resets to 0.
- rx_frame_err  out  1  stop bit sampled low on the last frame. Held until the next rx_done. Resets to 0.
- tx_start  in  1  transmit request.
- tx_data  in  DATA_BITS  payload, sampled when tx_start is accepted.
- tx_out  out  1  registered serial output. Resets to 1.
- tx_busy  out  1  frame in progress. Resets to 0.
- tx_done  out  1  one-cycle pulse in the last cycle of the frame. Resets to 0.

## Operation
- RX and TX are independent state machines. Each has its own prescaler, and the prescaler restarts when that path's frame starts.
- **RX input:** rx_in passes through a 2-flop synchronizer. Both flops reset to 1.
- **RX states:** IDLE → START → DATA → PARITY (only when PARITY≠0) → STOP → IDLE.
- **IDLE:** a synchronized low restarts the prescaler and moves to START.
- **START:** samples at tick OVERSAMPLE/2−1, which is mid-bit.
  - If the sample is high, treat it as a glitch and return to IDLE with no outputs.
  - If low, go to DATA.
- **DATA/PARITY/STOP:** each samples every OVERSAMPLE ticks from the start-bit midpoint.
  - Data is received LSB first.
  - The parity check is computed over the data bits (even: XOR of data and parity bit must be 0; odd: must be 1).
  - Only one stop bit is checked, regardless of STOP_BITS.
- **RX frame completion** happens in the cycle after the stop sample:
  - rx_data is loaded with the payload even when the frame has errors.
  - rx_done pulses.
  - Both error flags are updated.
  - rx_valid pulses only if both error flags are 0.
  - The state machine returns to IDLE. A new start edge is accepted from the next cycle.
- **TX states:** IDLE → START → DATA → PARITY (optional) → STOP → IDLE. Each bit lasts exactly BIT_CYCLES cycles.
- **TX accept:** tx_start is accepted only in IDLE. tx_data is latched, and parity is computed from the latched data.
- **TX while busy:** tx_start is ignored and has no queueing effect.
- **TX bit order:** data LSB first. STOP_BITS stop bits are sent, all high.

## Timing
- **TX:**
  - tx_start is sampled high in IDLE at edge N.
  - From N+1: tx_out=0 and tx_busy=1.
  - Frame length F = (1+DATA_BITS+(PARITY≠0)+STOP_BITS)*BIT_CYCLES cycles.
  - tx_busy is high for cycles N+1 … N+F.
  - tx_done pulses in cycle N+F.
  - tx_busy=0 from N+F+1.
  - The earliest back-to-back accept is at edge N+F+1.
- **RX:**
  - The first synchronized low appears 2 cycles after rx_in falls.
  - rx_done comes 1 cycle after the stop-bit mid-sample.
- **Reset mid-frame:** both machines return to IDLE on the next edge. tx_out=1, tx_busy=0, and all pulses are 0. rx_data and the error flags are cleared.
- **Simultaneous activity:** an RX frame completing while TX is active has no interaction between the two paths.

## Structure
- Shared package cc_uart_pkg holds:
  - the parity-mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - the state-encoding localparams shared by RX and TX;
  - the DIV/BIT_CYCLES derivation function.
- One sub-module, cc_uart_prescaler:
  - parameter PERIOD;
  - inputs clk, rst_n, restart;
  - outputs a one-cycle tick and a tick index counter.
- Instantiate cc_uart_prescaler twice:
  - RX with PERIOD=DIV;
  - TX with PERIOD=BIT_CYCLES.
- The RX and TX FSMs live in cc_uart_core itself.

## Test plan
Test parameters: CLK_FREQ=16_000_000, BAUD=1_000_000, OVERSAMPLE=16, which gives DIV=1 and BIT_CYCLES=16.
- **8N1 transmit:** tx_data=0xA5 with tx_start at edge 0.
  - tx_out is 0 for cycles 1–16.
  - Data bits are 1,0,1,0,0,1,0,1, 16 cycles each.
  - Stop bit is high for cycles 145–160.
  - tx_done pulses in cycle 160; tx_busy is high for cycles 1–160.
- **8E1 loopback:** tx_out connected to rx_in, send 0x3C.
  - Expect one rx_done with rx_data=0x3C and rx_valid=1.
  - Both error flags stay 0.
- **7O2 parity error:** drive a frame for 0x41 with the parity bit inverted.
  - rx_done=1, rx_parity_err=1, rx_valid=0, rx_data=0x41.
- **Frame error:** 8N1 frame for 0xFF with the stop bit driven low.
  - rx_frame_err=1 and rx_valid=0.
  - A following good frame for 0x12 clears rx_frame_err and gives rx_valid=1.
- **Glitch:** rx_in low for 4 cycles, then high.
  - No rx_done; the RX FSM is back in IDLE within 10 cycles.
- **Busy and reset:**
  - tx_start while tx_busy=1 → the frame is unchanged and no second frame is sent.
  - rst_n=0 in the middle of the data bits → tx_out=1 and tx_busy=0 on the next edge, with no tx_done.

Source files
------------

// File: rtl/cc_uart_pkg.sv
// cc_uart_pkg: parity modes, shared FSM encoding and baud divider derivation
package cc_uart_pkg;
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_t;

    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        return clk_freq / (baud * os);
    endfunction

    function automatic int calc_bit_cycles(input int clk_freq, input int baud, input int os);
        return calc_div(clk_freq, baud, os) * os;
    endfunction
endpackage

// File: rtl/cc_uart_prescaler.sv
// cc_uart_prescaler: restartable tick divider with a wrapping tick index
module cc_uart_prescaler #(
    parameter int PERIOD = 1,
    parameter int WRAP = 2,
    parameter int IW = $clog2(WRAP)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          restart,
    output logic          tick,
    output logic [IW-1:0] idx
);
    localparam int CW = PERIOD > 1 ? $clog2(PERIOD) : 1;
    logic [CW-1:0] cnt;
    assign tick = cnt == CW'(PERIOD - 1);
    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) idx <= idx == IW'(WRAP - 1) ? '0 : idx + IW'(1);
        end
    end
endmodule

// File: rtl/cc_uart_core.sv
// cc_uart_core: parametrised full-duplex UART with parity and framing error reporting
module cc_uart_core
    import cc_uart_pkg::*;
#(
    parameter int CLK_FREQ = 30_000_000,
    parameter int BAUD = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int BIT_CYCLES = calc_bit_cycles(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam bit HAS_PAR = PARITY != PAR_NONE;
    localparam int NBITS = 1 + DATA_BITS + (HAS_PAR ? 1 : 0) + STOP_BITS;
    localparam int RIW = $clog2(OVERSAMPLE);
    localparam logic [RIW-1:0] MID = RIW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] DATA_END = 4'(DATA_BITS);
    localparam logic [3:0] LAST = 4'(NBITS - 1);
    localparam logic ODD = PARITY == PAR_ODD;

    uart_state_t rx_state, rx_next, tx_state, tx_next;
    logic rx_m, rx_s, rx_tick, rx_sample, rx_par, par_err, tx_tick, tx_p;
    logic [RIW-1:0] rx_idx;
    logic [3:0] rx_cnt, tx_idx;
    logic [DATA_BITS-1:0] rx_shift, tx_sh;

    always_ff @(posedge clk) begin
        if (!rst_n) {rx_s, rx_m} <= 2'b11;
        else {rx_s, rx_m} <= {rx_m, rx_in};
    end

    cc_uart_prescaler #(.PERIOD(DIV), .WRAP(OVERSAMPLE)) u_rx_pre (
        .clk(clk), .rst_n(rst_n), .restart(rx_state == S_IDLE && !rx_s),
        .tick(rx_tick), .idx(rx_idx)
    );

    cc_uart_prescaler #(.PERIOD(BIT_CYCLES), .WRAP(16)) u_tx_pre (
        .clk(clk), .rst_n(rst_n), .restart(tx_state == S_IDLE && tx_start),
        .tick(tx_tick), .idx(tx_idx)
    );

    // every rx sample lands mid-bit, counted from the start-bit midpoint
    assign rx_sample = rx_tick && rx_idx == MID;
    assign par_err = HAS_PAR && ((^rx_shift ^ rx_par) != ODD);

    always_ff @(posedge clk) rx_state <= !rst_n ? S_IDLE : rx_next;

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:   if (!rx_s) rx_next = S_START;
            S_START:  if (rx_sample) rx_next = rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (rx_sample && rx_cnt == DATA_END - 4'd1) rx_next = HAS_PAR ? S_PARITY : S_STOP;
            S_PARITY: if (rx_sample) rx_next = S_STOP;
            S_STOP:   if (rx_sample) rx_next = S_IDLE;
            default:  rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_cnt <= '0;
            rx_shift <= '0;
            rx_par <= 1'b0;
            rx_data <= '0;
            rx_done <= 1'b0;
            rx_valid <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            rx_valid <= 1'b0;
            if (rx_state == S_START) rx_cnt <= '0;
            if (rx_sample && rx_state == S_DATA) begin
                rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                rx_cnt <= rx_cnt + 4'd1;
            end
            if (rx_sample && rx_state == S_PARITY) rx_par <= rx_s;
            if (rx_sample && rx_state == S_STOP) begin
                rx_data <= rx_shift;
                rx_done <= 1'b1;
                rx_parity_err <= par_err;
                rx_frame_err <= !rx_s;
                rx_valid <= !par_err && rx_s;
            end
        end
    end

    always_ff @(posedge clk) tx_state <= !rst_n ? S_IDLE : tx_next;

    // tx_idx counts completed bits of the current frame
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            S_IDLE:   if (tx_start) tx_next = S_START;
            S_START:  if (tx_tick) tx_next = S_DATA;
            S_DATA:   if (tx_tick && tx_idx == DATA_END) tx_next = HAS_PAR ? S_PARITY : S_STOP;
            S_PARITY: if (tx_tick) tx_next = S_STOP;
            S_STOP:   if (tx_tick && tx_idx == LAST) tx_next = S_IDLE;
            default:  tx_next = S_IDLE;
        endcase
    end

    assign tx_busy = tx_state != S_IDLE;
    assign tx_done = tx_state == S_STOP && tx_tick && tx_idx == LAST;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_out <= 1'b1;
            tx_sh <= '0;
            tx_p <= 1'b0;
        end else if (tx_state == S_IDLE && tx_start) begin
            tx_out <= 1'b0;
            tx_sh <= tx_data;
            tx_p <= PARITY == PAR_EVEN ? ^tx_data : ~^tx_data;
        end else if (tx_tick) begin
            tx_out <= tx_next == S_DATA ? tx_sh[0] : tx_next == S_PARITY ? tx_p : 1'b1;
            tx_sh <= tx_sh >> 1;
        end
    end
endmodule

// File: tb/tb_cc_uart_core.sv
// tb_cc_uart_core: directed checks of 8N1, 8E1 loopback and 7O2 instances
module tb_cc_uart_core;
    import cc_uart_pkg::*;

    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    logic rx_a = 1, tx_start_a = 0, tx_start_b = 0, rx_c = 1, tx_start_c = 0;
    logic [7:0] tx_data_a = 0, tx_data_b = 0, rx_data_a, rx_data_b;
    logic [6:0] tx_data_c = 0, rx_data_c;
    logic rx_done_a, rx_valid_a, rx_perr_a, rx_ferr_a, tx_out_a, tx_busy_a, tx_done_a;
    logic rx_done_b, rx_valid_b, rx_perr_b, rx_ferr_b, tx_out_b, tx_busy_b, tx_done_b;
    logic rx_done_c, rx_valid_c, rx_perr_c, rx_ferr_c, tx_out_c, tx_busy_c, tx_done_c;

    cc_uart_core #(.CLK_FREQ(16_000_000), .BAUD(1_000_000), .OVERSAMPLE(16),
                   .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_a), .rx_data(rx_data_a), .rx_done(rx_done_a),
        .rx_valid(rx_valid_a), .rx_parity_err(rx_perr_a), .rx_frame_err(rx_ferr_a),
        .tx_start(tx_start_a), .tx_data(tx_data_a), .tx_out(tx_out_a), .tx_busy(tx_busy_a),
        .tx_done(tx_done_a));

    cc_uart_core #(.CLK_FREQ(16_000_000), .BAUD(1_000_000), .OVERSAMPLE(16),
                   .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_b (
        .clk(clk), .rst_n(rst_n), .rx_in(tx_out_b), .rx_data(rx_data_b), .rx_done(rx_done_b),
        .rx_valid(rx_valid_b), .rx_parity_err(rx_perr_b), .rx_frame_err(rx_ferr_b),
        .tx_start(tx_start_b), .tx_data(tx_data_b), .tx_out(tx_out_b), .tx_busy(tx_busy_b),
        .tx_done(tx_done_b));

    cc_uart_core #(.CLK_FREQ(16_000_000), .BAUD(1_000_000), .OVERSAMPLE(16),
                   .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_c (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_c), .rx_data(rx_data_c), .rx_done(rx_done_c),
        .rx_valid(rx_valid_c), .rx_parity_err(rx_perr_c), .rx_frame_err(rx_ferr_c),
        .tx_start(tx_start_c), .tx_data(tx_data_c), .tx_out(tx_out_c), .tx_busy(tx_busy_c),
        .tx_done(tx_done_c));

    int tests = 0, fails = 0;
    int na = 0, nb = 0, nc = 0, ta = 0;
    logic va, vb, vc;
    logic [8:0] da, db, dc;

    always @(negedge clk) begin
        if (rx_done_a) begin na++; va = rx_valid_a; da = 9'(rx_data_a); end
        if (rx_done_b) begin nb++; vb = rx_valid_b; db = 9'(rx_data_b); end
        if (rx_done_c) begin nc++; vc = rx_valid_c; dc = 9'(rx_data_c); end
        if (tx_done_a) ta++;
    end

    function automatic logic [170:0] exp_out(input logic [7:0] v);
        logic [170:0] r = '0;
        for (int c = 1; c <= 170; c++) r[c] = c <= 16 ? 1'b0 : c <= 144 ? v[(c - 17) / 16] : 1'b1;
        return r;
    endfunction

    function automatic logic [170:0] exp_busy();
        logic [170:0] r = '0;
        for (int c = 1; c <= 160; c++) r[c] = 1'b1;
        return r;
    endfunction

    function automatic logic [170:0] exp_done();
        logic [170:0] r = '0;
        r[160] = 1'b1;
        return r;
    endfunction

    task automatic tx_trace(input logic [7:0] data, input int poke,
                            output logic [170:0] o, output logic [170:0] b, output logic [170:0] d);
        o = '0; b = '0; d = '0;
        tx_data_a = data;
        tx_start_a = 1;
        @(negedge clk);
        tx_start_a = 0;
        for (int c = 1; c <= 170; c++) begin
            o[c] = tx_out_a; b[c] = tx_busy_a; d[c] = tx_done_a;
            tx_start_a = c == poke;
            if (c == poke) tx_data_a = ~data;
            @(negedge clk);
        end
        tx_start_a = 0;
    endtask

    task automatic drive_rx(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) rx_a = bits[i]; else rx_c = bits[i];
            repeat (16) @(negedge clk);
        end
        rx_a = 1; rx_c = 1;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        tests++; if (tx_out_a !== 1'b1) begin fails++; $display("FAIL reset tx_out got %b want 1", tx_out_a); end
        tests++; if ({tx_busy_a, tx_done_a} !== 2'b00) begin fails++; $display("FAIL reset tx_busy/done got %b want 00", {tx_busy_a, tx_done_a}); end
        tests++; if ({rx_done_a, rx_valid_a, rx_perr_a, rx_ferr_a} !== 4'b0000) begin fails++; $display("FAIL reset rx flags got %b want 0000", {rx_done_a, rx_valid_a, rx_perr_a, rx_ferr_a}); end
        tests++; if (rx_data_a !== 8'h00) begin fails++; $display("FAIL reset rx_data got %h want 00", rx_data_a); end
        rst_n = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tx_8n1();
        logic [170:0] o, b, d;
        tx_trace(8'hA5, 0, o, b, d);
        tests++; if (o !== exp_out(8'hA5)) begin fails++; $display("FAIL tx8n1 out got %h want %h", o, exp_out(8'hA5)); end
        tests++; if (b !== exp_busy()) begin fails++; $display("FAIL tx8n1 busy got %h want %h", b, exp_busy()); end
        tests++; if (d !== exp_done()) begin fails++; $display("FAIL tx8n1 done got %h want %h", d, exp_done()); end
    endtask

    task automatic test_loopback_8e1();
        int k = 0, n0 = nb;
        tx_data_b = 8'h3C;
        tx_start_b = 1;
        @(negedge clk);
        tx_start_b = 0;
        while (!tx_done_b && k < 400) begin @(negedge clk); k++; end
        tests++; if (tx_done_b !== 1'b1) begin fails++; $display("FAIL lb tx_done timeout got %b want 1", tx_done_b); end
        repeat (30) @(negedge clk);
        tests++; if (nb - n0 !== 1) begin fails++; $display("FAIL lb rx_done count got %0d want 1", nb - n0); end
        tests++; if (db !== 9'h03C) begin fails++; $display("FAIL lb rx_data got %h want 03c", db); end
        tests++; if (vb !== 1'b1) begin fails++; $display("FAIL lb rx_valid got %b want 1", vb); end
        tests++; if ({rx_perr_b, rx_ferr_b} !== 2'b00) begin fails++; $display("FAIL lb err flags got %b want 00", {rx_perr_b, rx_ferr_b}); end
    endtask

    task automatic test_parity_7o2();
        int n0 = nc;
        drive_rx(1, 16'h0682, 11);
        tests++; if (nc - n0 !== 1) begin fails++; $display("FAIL 7o2 bad rx_done count got %0d want 1", nc - n0); end
        tests++; if (rx_perr_c !== 1'b1) begin fails++; $display("FAIL 7o2 bad parity_err got %b want 1", rx_perr_c); end
        tests++; if (vc !== 1'b0) begin fails++; $display("FAIL 7o2 bad rx_valid got %b want 0", vc); end
        tests++; if (dc !== 9'h041) begin fails++; $display("FAIL 7o2 bad rx_data got %h want 041", dc); end
        tests++; if (rx_ferr_c !== 1'b0) begin fails++; $display("FAIL 7o2 bad frame_err got %b want 0", rx_ferr_c); end
        drive_rx(1, 16'h0782, 11);
        tests++; if ({rx_perr_c, vc} !== 2'b01) begin fails++; $display("FAIL 7o2 good perr/valid got %b want 01", {rx_perr_c, vc}); end
    endtask

    task automatic test_frame_err();
        int n0 = na;
        drive_rx(0, 16'h01FE, 10);
        tests++; if (rx_ferr_a !== 1'b1) begin fails++; $display("FAIL ferr flag got %b want 1", rx_ferr_a); end
        tests++; if (va !== 1'b0) begin fails++; $display("FAIL ferr rx_valid got %b want 0", va); end
        tests++; if (da !== 9'h0FF) begin fails++; $display("FAIL ferr rx_data got %h want 0ff", da); end
        drive_rx(0, 16'h0224, 10);
        tests++; if (na - n0 !== 2) begin fails++; $display("FAIL ferr rx_done count got %0d want 2", na - n0); end
        tests++; if (rx_ferr_a !== 1'b0) begin fails++; $display("FAIL ferr clear got %b want 0", rx_ferr_a); end
        tests++; if (va !== 1'b1) begin fails++; $display("FAIL ferr good rx_valid got %b want 1", va); end
        tests++; if (da !== 9'h012) begin fails++; $display("FAIL ferr good rx_data got %h want 012", da); end
    endtask

    task automatic test_glitch();
        int n0 = na;
        rx_a = 0;
        repeat (4) @(negedge clk);
        rx_a = 1;
        repeat (10) @(negedge clk);
        tests++; if (u_a.rx_state !== S_IDLE) begin fails++; $display("FAIL glitch rx_state got %0d want %0d", u_a.rx_state, S_IDLE); end
        repeat (20) @(negedge clk);
        tests++; if (na - n0 !== 0) begin fails++; $display("FAIL glitch rx_done count got %0d want 0", na - n0); end
    endtask

    task automatic test_busy(input int poke);
        logic [170:0] o, b, d;
        tx_trace(8'h5A, poke, o, b, d);
        tests++; if (o !== exp_out(8'h5A)) begin fails++; $display("FAIL busy poke%0d out got %h want %h", poke, o, exp_out(8'h5A)); end
        tests++; if (b !== exp_busy()) begin fails++; $display("FAIL busy poke%0d busy got %h want %h", poke, b, exp_busy()); end
        tests++; if (d !== exp_done()) begin fails++; $display("FAIL busy poke%0d done got %h want %h", poke, d, exp_done()); end
    endtask

    task automatic test_back_to_back();
        logic [170:0] o, b, d;
        tx_trace(8'hC3, 0, o, b, d);
        tx_trace(8'h3C, 0, o, b, d);
        tests++; if (o !== exp_out(8'h3C)) begin fails++; $display("FAIL b2b out got %h want %h", o, exp_out(8'h3C)); end
    endtask

    task automatic test_mid_reset();
        int t0 = ta;
        tx_data_a = 8'hA5;
        tx_start_a = 1;
        @(negedge clk);
        tx_start_a = 0;
        repeat (39) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        tests++; if ({tx_out_a, tx_busy_a, tx_done_a} !== 3'b100) begin fails++; $display("FAIL midrst tx out/busy/done got %b want 100", {tx_out_a, tx_busy_a, tx_done_a}); end
        tests++; if (rx_data_a !== 8'h00) begin fails++; $display("FAIL midrst rx_data got %h want 00", rx_data_a); end
        tests++; if (rx_data_c !== 7'h00) begin fails++; $display("FAIL midrst 7o2 rx_data got %h want 00", rx_data_c); end
        rst_n = 1;
        repeat (200) @(negedge clk);
        tests++; if (ta - t0 !== 0) begin fails++; $display("FAIL midrst tx_done count got %0d want 0", ta - t0); end
        tests++; if ({tx_out_a, tx_busy_a} !== 2'b10) begin fails++; $display("FAIL midrst idle out/busy got %b want 10", {tx_out_a, tx_busy_a}); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_tx_8n1();
        test_loopback_8e1();
        test_parity_7o2();
        test_frame_err();
        test_glitch();
        test_busy(60);
        test_busy(160);
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
